// File: rtl/ixc_sfifo_rd_arb.sv
// Round-robin read arbiter for a shared SFIFO read port: grants one channel per packet and issues beats on oRdy.
// Define IXC_SFIFO_RD_ARB_WHOLE_PKT_EN to require a whole packet resident before a channel is eligible.
module ixc_sfifo_rd_arb #(
  parameter int NCH  = 4,
  parameter int LENW = 16,
  parameter int AVW  = 18
) (
  input  logic                     scgGFreq,
  input  logic                     rstN,
  input  logic [NCH-1:0]           reqV,
  input  logic [NCH*LENW-1:0]      reqLen,
  input  logic [NCH*AVW-1:0]       avail,
  input  logic                     oRdy,
  output logic                     rdEn,
  output logic [$clog2(NCH)-1:0]   rdCh,
  output logic [NCH-1:0]           gnt,
  output logic [NCH-1:0]           reqAck,
  output logic [63:0]              rdCnt,
  output logic                     busy
);

  localparam int CHW = $clog2(NCH);
  localparam int CW  = (AVW > LENW) ? AVW : LENW;

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t          state, state_nx;
  logic [CHW-1:0]  rr_ptr, cur_ch, pick, idx;
  logic            pick_ok, last;
  logic [LENW-1:0] remaining, pick_len;
  logic [NCH-1:0]  elig;
  logic [AVW-1:0]  cur_avail;
  logic [CW-1:0]   a_ext;
`ifdef IXC_SFIFO_RD_ARB_WHOLE_PKT_EN
  logic [CW-1:0]   l_ext;
`endif

  always_comb begin
    elig  = '0;
    a_ext = '0;
`ifdef IXC_SFIFO_RD_ARB_WHOLE_PKT_EN
    l_ext = '0;
`endif
    for (int unsigned i = 0; i < NCH; i++) begin
      a_ext = CW'(avail[AVW*i +: AVW]);
`ifdef IXC_SFIFO_RD_ARB_WHOLE_PKT_EN
      l_ext = CW'(reqLen[LENW*i +: LENW]);
      if (l_ext == '0) l_ext = CW'(1);
      elig[i] = reqV[i] && (a_ext >= l_ext);
`else
      elig[i] = reqV[i] && (a_ext != '0);
`endif
    end
  end

  // First eligible channel at or above rr_ptr; NCH is a power of two so the index wraps naturally.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = rr_ptr + CHW'(k);
      if (!pick_ok && elig[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    pick_len  = '0;
    cur_avail = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (CHW'(i) == pick)   pick_len  = reqLen[LENW*i +: LENW];
      if (CHW'(i) == cur_ch) cur_avail = avail[AVW*i +: AVW];
    end
  end

  always_comb begin
    rdEn     = (state == XFER) && oRdy && (cur_avail != '0);
    last     = rdEn && (remaining == LENW'(1));
    gnt      = (state == XFER) ? (NCH'(1) << cur_ch) : '0;
    reqAck   = last ? gnt : '0;
    busy     = (state != IDLE);
    rdCh     = cur_ch;
    state_nx = state;
    case (state)
      IDLE:    if (|elig) state_nx = ARB;
      ARB:     state_nx = pick_ok ? XFER : IDLE;
      XFER:    if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge scgGFreq) begin
    if (!rstN) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      remaining <= '0;
      rdCnt     <= '0;
    end else begin
      state <= state_nx;
      if (state == ARB && pick_ok) begin
        cur_ch    <= pick;
        remaining <= (pick_len == '0) ? LENW'(1) : pick_len;
      end
      if (rdEn) begin
        remaining <= remaining - LENW'(1);
        rdCnt     <= rdCnt + 64'd1;
      end
      if (last) rr_ptr <= cur_ch + CHW'(1);
    end
  end

endmodule

// File: tb/tb_ixc_sfifo_rd_arb.sv
// Bench for ixc_sfifo_rd_arb: directed scenarios plus randomized traffic against a packet-level model.
module tb_ixc_sfifo_rd_arb;
  localparam int NCH = 4, LENW = 16, AVW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NCH-1:0]      req_v;
  logic [LENW-1:0]     len [NCH];
  logic [AVW-1:0]      av [NCH];
  logic                o_rdy;
  logic [NCH*LENW-1:0] len_bus;
  logic [NCH*AVW-1:0]  av_bus;
  logic                rd_en, busy;
  logic [1:0]          rd_ch;
  logic [NCH-1:0]      gnt, req_ack;
  logic [63:0]         rd_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always_comb begin
    len_bus = '0;
    av_bus  = '0;
    for (int i = 0; i < NCH; i++) begin
      len_bus[LENW*i +: LENW] = len[i];
      av_bus[AVW*i +: AVW]    = av[i];
    end
  end

  ixc_sfifo_rd_arb #(.NCH(NCH), .LENW(LENW), .AVW(AVW)) dut (
    .scgGFreq(clk), .rstN(rst_n), .reqV(req_v), .reqLen(len_bus), .avail(av_bus),
    .oRdy(o_rdy), .rdEn(rd_en), .rdCh(rd_ch), .gnt(gnt), .reqAck(req_ack),
    .rdCnt(rd_cnt), .busy(busy)
  );

  task automatic adv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic apply_reset();
    req_v = '0;
    o_rdy = 1'b0;
    for (int i = 0; i < NCH; i++) begin len[i] = '0; av[i] = '0; end
    rst_n = 1'b0;
    adv(); adv();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    smp();
    n_cmp++;
    if ({rd_en, busy, gnt, req_ack, rd_ch} !== 12'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 000", {rd_en, busy, gnt, req_ack, rd_ch});
    end
    n_cmp++;
    if (rd_cnt !== 64'd0) begin n_bad++; $display("FAIL reset_rdcnt: got %0d want 0", rd_cnt); end
    adv();
  endtask

  task automatic test_single();
    logic exp_en;
    logic [3:0] exp_ack;
    apply_reset();
    req_v[1] = 1'b1; len[1] = 16'd3; av[1] = 18'd10; o_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) req_v[1] = 1'b0;
      smp();
      exp_en  = (c >= 2 && c <= 4);
      exp_ack = (c == 4) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (rd_en !== exp_en) begin n_bad++; $display("FAIL single_rden c=%0d: got %b want %b", c, rd_en, exp_en); end
      n_cmp++;
      if (req_ack !== exp_ack) begin n_bad++; $display("FAIL single_ack c=%0d: got %b want %b", c, req_ack, exp_ack); end
      if (exp_en) begin
        n_cmp++;
        if (rd_ch !== 2'd1 || gnt !== 4'b0010) begin
          n_bad++; $display("FAIL single_grant c=%0d: got ch=%0d gnt=%b want ch=1 gnt=0010", c, rd_ch, gnt);
        end
      end
      adv();
    end
    smp();
    n_cmp++;
    if (rd_cnt !== 64'd3) begin n_bad++; $display("FAIL single_rdcnt: got %0d want 3", rd_cnt); end
    adv();
  endtask

  task automatic test_rr_order();
    int grants = 0, acks = 0, beats = 0, last_ack_c = 0;
    logic [3:0] prev_gnt = '0;
    apply_reset();
    o_rdy = 1'b1;
    for (int i = 0; i < NCH; i++) begin req_v[i] = 1'b1; len[i] = 16'd2; av[i] = 18'd1000; end
    for (int c = 0; c < 300 && acks < 8; c++) begin
      smp();
      if (gnt != 4'b0 && prev_gnt == 4'b0) begin
        n_cmp++;
        if (gnt !== (4'b0001 << (grants % 4))) begin
          n_bad++; $display("FAIL rr_grant #%0d: got %b want %b", grants, gnt, 4'b0001 << (grants % 4));
        end
        if (grants > 0) begin
          n_cmp++;
          if (c - last_ack_c != 3) begin n_bad++; $display("FAIL rr_gap: got %0d want 3", c - last_ack_c); end
        end
        grants++;
        beats = 0;
      end
      if (rd_en) beats++;
      if (req_ack != 4'b0) begin
        n_cmp++;
        if (req_ack !== gnt || beats != 2) begin
          n_bad++; $display("FAIL rr_ack: got ack=%b beats=%0d want ack=%b beats=2", req_ack, beats, gnt);
        end
        acks++;
        last_ack_c = c;
      end
      prev_gnt = gnt;
      adv();
    end
    n_cmp++;
    if (acks != 8) begin n_bad++; $display("FAIL rr_timeout: got %0d acks want 8", acks); end
    smp();
    n_cmp++;
    if (rd_cnt !== 64'd16) begin n_bad++; $display("FAIL rr_rdcnt: got %0d want 16", rd_cnt); end
    adv();
    req_v = '0;
  endtask

  task automatic test_stall();
    logic exp_en;
    logic [3:0] exp_gnt, exp_ack;
    apply_reset();
    req_v[0] = 1'b1; len[0] = 16'd4; av[0] = 18'd100;
    len[2] = 16'd1; av[2] = 18'd100;
    for (int c = 0; c < 14; c++) begin
      o_rdy = !(c >= 3 && c <= 5);
      if (c == 3)  req_v[2] = 1'b1;
      if (c == 9)  req_v[0] = 1'b0;
      if (c == 12) req_v[2] = 1'b0;
      smp();
      exp_en  = (c == 2) || (c >= 6 && c <= 8) || (c == 11);
      exp_gnt = (c >= 2 && c <= 8) ? 4'b0001 : (c == 11) ? 4'b0100 : 4'b0000;
      exp_ack = (c == 8) ? 4'b0001 : (c == 11) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (rd_en !== exp_en) begin n_bad++; $display("FAIL stall_rden c=%0d: got %b want %b", c, rd_en, exp_en); end
      n_cmp++;
      if (gnt !== exp_gnt) begin n_bad++; $display("FAIL stall_gnt c=%0d: got %b want %b", c, gnt, exp_gnt); end
      n_cmp++;
      if (req_ack !== exp_ack) begin n_bad++; $display("FAIL stall_ack c=%0d: got %b want %b", c, req_ack, exp_ack); end
      adv();
    end
  endtask

  task automatic test_avail();
    logic [15:0] pat = '0;
    logic [15:0] exp_pat;
    int n = 0, stall = 0, exp_n;
    bit done = 0, refilled = 0, beat;
    apply_reset();
    req_v[3] = 1'b1; len[3] = 16'd5; o_rdy = 1'b1;
`ifdef IXC_SFIFO_RD_ARB_WHOLE_PKT_EN
    exp_n = 5; exp_pat = 16'b11111;
    for (int c = 0; c < 8; c++) begin
      av[3] = (c < 4) ? 18'd2 : 18'd4;
      smp();
      n_cmp++;
      if (gnt !== 4'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL avail_early c=%0d: got gnt=%b busy=%b want 0000 0", c, gnt, busy);
      end
      adv();
    end
    av[3] = 18'd5;
    refilled = 1;
`else
    exp_n = 9; exp_pat = 16'b110000111;
    av[3] = 18'd2;
`endif
    for (int c = 0; c < 60 && !done; c++) begin
      smp();
      beat = rd_en;
      if (gnt[3]) begin pat = {pat[14:0], rd_en}; n++; end
      if (gnt[3] && !rd_en) stall++;
      if (req_ack[3]) begin
        done = 1;
        n_cmp++;
        if (!rd_en) begin n_bad++; $display("FAIL avail_ack_beat: got rden=0 want 1"); end
      end
      adv();
      if (beat) av[3] = av[3] - 18'd1;
      if (stall == 4 && !refilled) begin av[3] = 18'd10; refilled = 1; end
      if (done) req_v[3] = 1'b0;
    end
    n_cmp++;
    if (n != exp_n || pat !== exp_pat) begin
      n_bad++; $display("FAIL avail_pattern: got n=%0d pat=%b want n=%0d pat=%b", n, pat, exp_n, exp_pat);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_ack = 0, done = 0;
    int beats = 0;
    apply_reset();
    req_v[1] = 1'b1; len[1] = 16'd6; av[1] = 18'd100; o_rdy = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      rst_n = (c == 3) ? 1'b0 : 1'b1;
      smp();
      if (c == 3) begin
        n_cmp++;
        if (rd_en !== 1'b1) begin n_bad++; $display("FAIL rmid_beat2: got %b want 1", rd_en); end
      end
      if (c == 4) begin
        n_cmp++;
        if ({rd_en, busy, gnt} !== 6'd0) begin n_bad++; $display("FAIL rmid_clear: got %b want 000000", {rd_en, busy, gnt}); end
        n_cmp++;
        if (rd_cnt !== 64'd0) begin n_bad++; $display("FAIL rmid_rdcnt: got %0d want 0", rd_cnt); end
      end
      if (c <= 4 && req_ack != 4'b0) saw_ack = 1;
      if (c > 4 && rd_en) beats++;
      if (c > 4 && req_ack[1]) begin
        done = 1;
        n_cmp++;
        if (beats != 6) begin n_bad++; $display("FAIL rmid_beats: got %0d want 6", beats); end
      end
      adv();
    end
    req_v[1] = 1'b0;
    n_cmp++;
    if (saw_ack) begin n_bad++; $display("FAIL rmid_noack: got ack=1 want 0"); end
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL rmid_timeout: got done=0 want 1"); end
    smp();
    n_cmp++;
    if (rd_cnt !== 64'd6) begin n_bad++; $display("FAIL rmid_final_cnt: got %0d want 6", rd_cnt); end
    adv();
  endtask

  task automatic test_len0();
    logic exp_en;
    logic [3:0] exp_ack;
    apply_reset();
    req_v[2] = 1'b1; len[2] = 16'd0; av[2] = 18'd5; o_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) req_v[2] = 1'b0;
      smp();
      exp_en  = (c == 2);
      exp_ack = (c == 2) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (rd_en !== exp_en) begin n_bad++; $display("FAIL len0_rden c=%0d: got %b want %b", c, rd_en, exp_en); end
      n_cmp++;
      if (req_ack !== exp_ack) begin n_bad++; $display("FAIL len0_ack c=%0d: got %b want %b", c, req_ack, exp_ack); end
      adv();
    end
    smp();
    n_cmp++;
    if (rd_cnt !== 64'd1) begin n_bad++; $display("FAIL len0_rdcnt: got %0d want 1", rd_cnt); end
    adv();
  endtask

  // Packet-level model: a pending request waits one idle and one arbitration cycle, then the
  // next pending channel after the last winner owns the port for max(len,1) ready cycles.
  task automatic test_random();
    bit pend [NCH];
    int favour = 0, pick = 0, eff = 1, beats = 0;
    logic [63:0] total = '0;
    logic [3:0] prev_gnt = '0, exp_gnt, exp_ack;
    bit prev_busy = 0, prev_any = 0, prev_ack = 0, exp_busy, exp_en;
    apply_reset();
    for (int i = 0; i < NCH; i++) begin pend[i] = 0; av[i] = 18'd1000; end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++)
        if (!pend[i] && $urandom_range(3) == 0) begin pend[i] = 1; len[i] = LENW'($urandom_range(6)); end
      if (prev_gnt != 4'b0 && !prev_ack) len[pick] = LENW'($urandom_range(6));
      for (int i = 0; i < NCH; i++) req_v[i] = pend[i];
      o_rdy = ($urandom_range(3) != 0);
      smp();
      if (prev_ack || (!prev_busy && !prev_any)) begin exp_busy = 0; exp_gnt = '0; end
      else if (!prev_busy)                        begin exp_busy = 1; exp_gnt = '0; end
      else if (prev_gnt == 4'b0)                  begin exp_busy = 1; exp_gnt = 4'b0001 << pick; end
      else                                        begin exp_busy = 1; exp_gnt = prev_gnt; end
      if (exp_busy && exp_gnt == 4'b0) begin
        for (int k = NCH - 1; k >= 0; k--)
          if (pend[(favour + k) % NCH]) pick = (favour + k) % NCH;
        eff = (len[pick] == '0) ? 1 : int'(len[pick]);
        beats = 0;
      end
      exp_en  = (exp_gnt != 4'b0) && o_rdy;
      exp_ack = (exp_en && beats + 1 == eff) ? exp_gnt : 4'b0;
      n_cmp++;
      if (busy !== exp_busy || gnt !== exp_gnt) begin
        n_bad++; $display("FAIL rnd_grant c=%0d: got busy=%b gnt=%b want busy=%b gnt=%b", c, busy, gnt, exp_busy, exp_gnt);
      end
      n_cmp++;
      if (rd_en !== exp_en) begin n_bad++; $display("FAIL rnd_rden c=%0d: got %b want %b", c, rd_en, exp_en); end
      n_cmp++;
      if (req_ack !== exp_ack) begin n_bad++; $display("FAIL rnd_ack c=%0d: got %b want %b", c, req_ack, exp_ack); end
      if (exp_gnt != 4'b0) begin
        n_cmp++;
        if (rd_ch !== 2'(pick)) begin n_bad++; $display("FAIL rnd_rdch c=%0d: got %0d want %0d", c, rd_ch, pick); end
      end
      n_cmp++;
      if (rd_cnt !== total) begin n_bad++; $display("FAIL rnd_rdcnt c=%0d: got %0d want %0d", c, rd_cnt, total); end
      if (exp_en) begin beats++; total++; end
      prev_ack = (exp_ack != 4'b0);
      if (prev_ack) begin favour = (pick + 1) % NCH; pend[pick] = 0; end
      prev_busy = exp_busy;
      prev_gnt  = exp_gnt;
      prev_any  = |req_v;
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_stall();
    test_avail();
    test_reset_mid();
    test_len0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
